pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MD_CYCLES, default 8: total stall cycles for a multiply/divide (HI/LO) op; legal range 2..63.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low; sampled on rising clk edge.
REQ-004 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-006 id_muldiv  in  1  ID instruction is a HI/LO multiply/divide.
REQ-007 ex_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_rf_enable, ex_load  in  1 each  EX instruction writes the register file / is a load.
REQ-009 mem_rd, wb_rd  in  5 each  destination registers in MEM and WB.
REQ-010 mem_rf_enable, wb_rf_enable  in  1 each  MEM / WB instruction writes the register file.
REQ-011 ex_branch_taken  in  1  branch/jump resolved taken in EX.
REQ-012 pc_le, ifid_le  out  1 each  load enables for PC and IF/ID; 0 = hold.
REQ-013 idex_nop  out  1  forces the ID/EX register to capture all-zero control signals (bubble).
REQ-014 ifid_flush  out  1  forces IF/ID to capture a NOP.
REQ-015 fwd_a, fwd_b  out  2 each  operand source select for rs / rt: 00 RF, 01 EX, 10 MEM, 11 WB.
REQ-016 md_busy  out  1  multiply/divide stall in progress.
REQ-017 stall_count  out  16  count of cycles with pc_le=0.

Function
REQ-018 Forwarding is combinational: fwd_a = 01 if ex_rf_enable, !ex_load, ex_rd!=0, ex_rd==id_rs; else 10 if mem_rf_enable, mem_rd!=0, mem_rd==id_rs; else 11 if wb_rf_enable, wb_rd!=0, wb_rd==id_rs; else 00.
REQ-019 fwd_b is computed identically using id_rt; register 0 is never forwarded.
REQ-020 Load-use hazard (lu) = ex_load & ex_rf_enable & ex_rd!=0 & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
REQ-021 FSM states: RUN (00), MDBUSY (01); reset state RUN.
REQ-022 RUN: lu=1 -> pc_le=0, ifid_le=0, idex_nop=1 for that cycle only; state stays RUN.
REQ-023 RUN: id_muldiv=1 and lu=0 -> the muldiv passes into ID/EX normally this cycle, down-counter loads MD_CYCLES-1, next state MDBUSY.
REQ-024 RUN, lu=1 and id_muldiv=1 -> load-use stall wins; muldiv re-evaluated next cycle.
REQ-025 MDBUSY: pc_le=0, ifid_le=0, idex_nop=1, md_busy=1; counter decrements each cycle; counter==1 -> next state RUN, counter 0.
REQ-026 MDBUSY lasts exactly MD_CYCLES-1 cycles; total muldiv occupancy MD_CYCLES cycles.
REQ-027 ex_branch_taken=1 in RUN -> ifid_flush=1 that cycle, independent of lu; pc_le, ifid_le stay 1 unless lu.
REQ-028 ex_branch_taken in MDBUSY is ignored (ifid_flush=0).
REQ-029 Outside stalls: pc_le=1, ifid_le=1, idex_nop=0, md_busy=0.
REQ-030 stall_count increments by 1 on each clk edge where pc_le=0; saturates at 16'hFFFF, no wrap.

Reset
REQ-031 reset=0 at a clk edge -> state RUN, down-counter 0, stall_count 0, including mid-MDBUSY.
REQ-032 While reset=0: pc_le=1, ifid_le=1, idex_nop=0, ifid_flush=0, md_busy=0; fwd_a/fwd_b remain combinational.
REQ-033 First edge with reset=1 operates normally; no extra bubble inserted.

Verification
REQ-034 ex_load=1, ex_rf_enable=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> one cycle pc_le=0, idex_nop=1; stall_count 0->1.
REQ-035 ex_rd=3 non-load, mem_rd=3, wb_rd=3, all enables=1, id_rs=3 -> fwd_a=01; with ex_rd=0 -> fwd_a=10; id_rt=0 with wb_rd=0 -> fwd_b=00.
REQ-036 MD_CYCLES=8, id_muldiv=1 in RUN -> md_busy high exactly 7 cycles, then RUN; stall_count +7.
REQ-037 reset=0 on 3rd MDBUSY cycle -> next cycle RUN, md_busy=0, stall_count=0.
REQ-038 ex_branch_taken=1 with lu=1 -> ifid_flush=1, pc_le=0, idex_nop=1 same cycle; in MDBUSY ex_branch_taken=1 -> ifid_flush=0.
REQ-039 Force stall_count to 16'hFFFF via long MDBUSY sequence -> further stalls keep 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage in-order pipeline.
// Produces the operand forwarding selects, the one-cycle load-use bubble,
// the taken-branch IF/ID flush and the multi-cycle HI/LO multiply/divide stall.
// It also keeps a saturating count of the cycles in which the PC was held.
module pipeline_hazard_ctrl #(
    parameter int MD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_muldiv,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rf_enable,
    input  logic        ex_load,
    input  logic [4:0]  mem_rd,
    input  logic        mem_rf_enable,
    input  logic [4:0]  wb_rd,
    input  logic        wb_rf_enable,
    input  logic        ex_branch_taken,
    output logic        pc_le,
    output logic        ifid_le,
    output logic        idex_nop,
    output logic        ifid_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        md_busy,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        MDBUSY = 2'b01
    } state_t;

    // The muldiv instruction itself occupies one RUN cycle, so the busy
    // phase covers the remaining MD_CYCLES-1 cycles.
    localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES - 1);

    state_t      state;
    logic [5:0]  md_cnt;
    logic [15:0] stall_cnt;
    logic        lu;

    // Youngest producer wins; a load in EX has no result yet, so it is
    // never a forwarding source (the load-use bubble covers that case).
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] e_rd, input logic e_en, input logic e_ld,
        input logic [4:0] m_rd, input logic m_en,
        input logic [4:0] w_rd, input logic w_en
    );
        if (e_en && !e_ld && e_rd != 5'd0 && e_rd == src)
            return 2'b01;
        else if (m_en && m_rd != 5'd0 && m_rd == src)
            return 2'b10;
        else if (w_en && w_rd != 5'd0 && w_rd == src)
            return 2'b11;
        else
            return 2'b00;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Forwarding selects stay live even while reset is asserted.
    always_comb begin
        fwd_a = fwd_sel(id_rs, ex_rd, ex_rf_enable, ex_load,
                        mem_rd, mem_rf_enable, wb_rd, wb_rf_enable);
        fwd_b = fwd_sel(id_rt, ex_rd, ex_rf_enable, ex_load,
                        mem_rd, mem_rf_enable, wb_rd, wb_rf_enable);
    end

    // Load-use hazard: ID needs a register the load in EX has not produced yet.
    always_comb begin
        lu = ex_load && ex_rf_enable && (ex_rd != 5'd0) &&
             ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
    end

    // Pipeline control decode from the FSM state and the current hazards;
    // everything is held at its pass-through value while reset is low.
    always_comb begin
        pc_le      = 1'b1;
        ifid_le    = 1'b1;
        idex_nop   = 1'b0;
        ifid_flush = 1'b0;
        md_busy    = 1'b0;
        if (reset) begin
            if (state == MDBUSY) begin
                pc_le    = 1'b0;
                ifid_le  = 1'b0;
                idex_nop = 1'b1;
                md_busy  = 1'b1;
            end else begin
                if (lu) begin
                    pc_le    = 1'b0;
                    ifid_le  = 1'b0;
                    idex_nop = 1'b1;
                end
                ifid_flush = ex_branch_taken;
            end
        end
    end

    // FSM, muldiv down-counter and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            md_cnt    <= 6'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (!pc_le)
                stall_cnt <= sat_inc(stall_cnt);
            case (state)
                RUN: begin
                    // A pending load-use bubble takes priority; the muldiv
                    // is seen again next cycle once the bubble has gone.
                    if (id_muldiv && !lu) begin
                        state  <= MDBUSY;
                        md_cnt <= MD_LOAD;
                    end
                end
                MDBUSY: begin
                    if (md_cnt == 6'd1) begin
                        state  <= RUN;
                        md_cnt <= 6'd0;
                    end else begin
                        md_cnt <= md_cnt - 6'd1;
                    end
                end
                default: begin
                    state  <= RUN;
                    md_cnt <= 6'd0;
                end
            endcase
        end
    end

    assign stall_count = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: vector table, hand-written sequences
// and randomized traffic compared against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int MD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rs, id_uses_rt, id_muldiv;
    logic        ex_rf_enable, ex_load, mem_rf_enable, wb_rf_enable, ex_branch_taken;
    logic        pc_le, ifid_le, idex_nop, ifid_flush, md_busy;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Model state: cycles of busy phase still to come, and the stall tally.
    int m_busy = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_CYCLES(MD)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_muldiv(id_muldiv),
        .ex_rd(ex_rd), .ex_rf_enable(ex_rf_enable), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_rf_enable(mem_rf_enable),
        .wb_rd(wb_rd), .wb_rf_enable(wb_rf_enable),
        .ex_branch_taken(ex_branch_taken),
        .pc_le(pc_le), .ifid_le(ifid_le), .idex_nop(idex_nop), .ifid_flush(ifid_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy), .stall_count(stall_count)
    );

    typedef struct {
        int rs, rt, urs, urt, exrd, exrf, exld, memrd, memrf, wbrd, wbrf, br;
        int fa, fb, pc, nop, fl;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Forwarding source: first of EX, MEM, WB (youngest first) that writes src.
    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        logic [4:0] rd[3];
        logic       en[3];
        rd = '{ex_rd, mem_rd, wb_rd};
        en = '{ex_rf_enable && !ex_load, mem_rf_enable, wb_rf_enable};
        for (int i = 0; i < 3; i++)
            if (en[i] && rd[i] != 5'd0 && rd[i] == src)
                return 2'(i + 1);
        return 2'b00;
    endfunction

    function automatic logic model_lu();
        return ex_load && ex_rf_enable && ex_rd != 5'd0 &&
               ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
    endfunction

    task automatic model_check(input string tag);
        logic busy, stall, flush;
        busy  = reset && (m_busy > 0);
        stall = reset && (m_busy > 0 || model_lu());
        flush = reset && (m_busy == 0) && ex_branch_taken;
        chk({tag, ".pc_le"},       32'(pc_le),       32'(!stall));
        chk({tag, ".ifid_le"},     32'(ifid_le),     32'(!stall));
        chk({tag, ".idex_nop"},    32'(idex_nop),    32'(stall));
        chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(flush));
        chk({tag, ".md_busy"},     32'(md_busy),     32'(busy));
        chk({tag, ".fwd_a"},       32'(fwd_a),       32'(exp_fwd(id_rs)));
        chk({tag, ".fwd_b"},       32'(fwd_b),       32'(exp_fwd(id_rt)));
        chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_cnt));
    endtask

    task automatic settle_check(input string tag);
        #3;
        model_check(tag);
    endtask

    // Advance the model with the inputs present at this edge, then the clock.
    task automatic tick();
        logic l;
        l = model_lu();
        if (!reset) begin
            m_busy = 0;
            m_cnt  = 0;
        end else begin
            if (m_busy > 0 || l)
                m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (m_busy > 0)
                m_busy--;
            else if (!l && id_muldiv)
                m_busy = MD - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_muldiv = 1'b0; ex_rd = 5'd0; ex_rf_enable = 1'b0; ex_load = 1'b0;
        mem_rd = 5'd0; mem_rf_enable = 1'b0; wb_rd = 5'd0; wb_rf_enable = 1'b0;
        ex_branch_taken = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        id_rs = 5'(v.rs); id_rt = 5'(v.rt);
        id_uses_rs = (v.urs != 0); id_uses_rt = (v.urt != 0);
        id_muldiv = 1'b0;
        ex_rd = 5'(v.exrd); ex_rf_enable = (v.exrf != 0); ex_load = (v.exld != 0);
        mem_rd = 5'(v.memrd); mem_rf_enable = (v.memrf != 0);
        wb_rd = 5'(v.wbrd); wb_rf_enable = (v.wbrf != 0);
        ex_branch_taken = (v.br != 0);
    endtask

    task automatic load_use_inputs();
        idle_inputs();
        id_rs = 5'd5; id_uses_rs = 1'b1;
        ex_rd = 5'd5; ex_rf_enable = 1'b1; ex_load = 1'b1;
    endtask

    initial begin
        int n;
        int base;
        //          rs rt urs urt exrd exrf exld memrd memrf wbrd wbrf br  fa fb pc nop fl
        vecs[0]  = '{5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0};
        vecs[1]  = '{3, 0, 1, 1, 3, 1, 0, 3, 1, 3, 1, 0,   1, 0, 1, 0, 0};
        vecs[2]  = '{3, 0, 1, 1, 0, 1, 0, 3, 1, 3, 1, 0,   2, 0, 1, 0, 0};
        vecs[3]  = '{3, 0, 1, 1, 3, 1, 0, 3, 1, 0, 1, 0,   1, 0, 1, 0, 0};
        vecs[4]  = '{7, 7, 1, 1, 7, 0, 0, 7, 1, 7, 1, 0,   2, 2, 1, 0, 0};
        vecs[5]  = '{9, 4, 0, 0, 9, 1, 1, 9, 0, 9, 1, 0,   3, 0, 1, 0, 0};
        vecs[6]  = '{1, 12, 1, 1, 12, 1, 1, 1, 1, 12, 1, 0, 2, 3, 0, 1, 0};
        vecs[7]  = '{0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 1, 0,   0, 0, 1, 0, 0};
        vecs[8]  = '{6, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0};
        vecs[9]  = '{6, 0, 1, 0, 6, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0};
        vecs[10] = '{2, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 1};
        vecs[11] = '{5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1};
        vecs[12] = '{2, 2, 1, 1, 2, 1, 0, 2, 1, 2, 1, 0,   1, 1, 1, 0, 0};

        // Reset held low with hazards present: controls pass through, forwarding live.
        reset = 1'b0;
        load_use_inputs();
        ex_branch_taken = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            settle_check("reset_hold");
            tick();
        end
        ex_load = 1'b0;
        settle_check("reset_fwd");
        chk("reset_fwd_a_ex", 32'(fwd_a), 32'd1);
        tick();

        // First edge out of reset behaves normally with no extra bubble.
        reset = 1'b1;
        idle_inputs();
        settle_check("reset_release");
        tick();
        settle_check("after_release");
        chk("after_release.stall_count", 32'(stall_count), 32'd0);
        tick();

        // Vector table in RUN.
        for (int i = 0; i < 13; i++) begin
            drive_vec(vecs[i]);
            #3;
            chk($sformatf("vec%0d.fwd_a", i),      32'(fwd_a),      32'(vecs[i].fa));
            chk($sformatf("vec%0d.fwd_b", i),      32'(fwd_b),      32'(vecs[i].fb));
            chk($sformatf("vec%0d.pc_le", i),      32'(pc_le),      32'(vecs[i].pc));
            chk($sformatf("vec%0d.idex_nop", i),   32'(idex_nop),   32'(vecs[i].nop));
            chk($sformatf("vec%0d.ifid_flush", i), 32'(ifid_flush), 32'(vecs[i].fl));
            model_check($sformatf("vec%0d", i));
            tick();
        end

        // Single load-use bubble advances stall_count by exactly one.
        idle_inputs();
        base = m_cnt;
        load_use_inputs();
        settle_check("lu_one");
        tick();
        idle_inputs();
        settle_check("lu_after");
        chk("lu_one.count_delta", 32'(stall_count), 32'(base + 1));
        tick();

        // Load-use and muldiv together: bubble first, muldiv taken next cycle.
        load_use_inputs();
        id_muldiv = 1'b1;
        settle_check("lu_vs_md");
        chk("lu_vs_md.md_busy", 32'(md_busy), 32'd0);
        tick();
        ex_load = 1'b0;
        settle_check("md_after_lu");
        tick();
        id_muldiv = 1'b0;
        settle_check("md_after_lu_busy");
        chk("md_after_lu_busy.md_busy", 32'(md_busy), 32'd1);
        for (int i = 0; i < MD + 2; i++) begin
            settle_check("md_drain");
            tick();
        end

        // Muldiv: busy exactly MD-1 cycles, branches ignored while busy.
        idle_inputs();
        base = m_cnt;
        id_muldiv = 1'b1;
        settle_check("md_issue");
        tick();
        id_muldiv = 1'b0;
        ex_branch_taken = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            settle_check("md_run");
            if (md_busy === 1'b1) begin
                n++;
                chk("md_busy.flush_ignored", 32'(ifid_flush), 32'd0);
            end
            tick();
        end
        chk("md_busy.cycles", 32'(n), 32'(MD - 1));
        chk("md_busy.count_delta", 32'(stall_count), 32'(base + MD - 1));

        // Reset during the third busy cycle aborts the muldiv stall.
        idle_inputs();
        id_muldiv = 1'b1;
        settle_check("mdr_issue");
        tick();
        id_muldiv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle_check("mdr_busy");
            tick();
        end
        reset = 1'b0;
        settle_check("mdr_reset");
        chk("mdr_reset.md_busy", 32'(md_busy), 32'd0);
        tick();
        reset = 1'b1;
        settle_check("mdr_after");
        chk("mdr_after.md_busy", 32'(md_busy), 32'd0);
        chk("mdr_after.stall_count", 32'(stall_count), 32'd0);
        chk("mdr_after.pc_le", 32'(pc_le), 32'd1);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) != 0);
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom_range(0, 1));
            id_uses_rt = 1'($urandom_range(0, 1));
            id_muldiv = ($urandom_range(0, 9) == 0);
            ex_rd = 5'($urandom_range(0, 3));
            ex_rf_enable = 1'($urandom_range(0, 1));
            ex_load = 1'($urandom_range(0, 1));
            mem_rd = 5'($urandom_range(0, 3));
            mem_rf_enable = 1'($urandom_range(0, 1));
            wb_rd = 5'($urandom_range(0, 3));
            wb_rf_enable = 1'($urandom_range(0, 1));
            ex_branch_taken = 1'($urandom_range(0, 1));
            settle_check("rand");
            tick();
        end

        // Drive stall_count into saturation and confirm it sticks.
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        load_use_inputs();
        for (int i = 0; i < 65530; i++)
            tick();
        settle_check("sat_pre");
        idle_inputs();
        id_muldiv = 1'b1;
        settle_check("sat_md_issue");
        tick();
        id_muldiv = 1'b0;
        for (int i = 0; i < MD - 1; i++) begin
            settle_check("sat_md");
            tick();
        end
        settle_check("sat_md_done");
        chk("sat.after_md", 32'(stall_count), 32'hFFFF);
        load_use_inputs();
        for (int i = 0; i < 3; i++) begin
            settle_check("sat_lu");
            tick();
            chk("sat.hold", 32'(stall_count), 32'hFFFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
